// File: rtl/cr_fifo_arb_pkg.sv
// rtl/cr_fifo_arb_pkg.sv - shared types and defaults for the FIFO write-port arbiter
package cr_fifo_arb_pkg;

   localparam int N_DEF     = 4;
   localparam int DW_DEF    = 71;
   localparam int SW_DEF    = 12;
   localparam int CNT_W_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int GW_DEF = idx_w(N_DEF);

endpackage

// File: rtl/cr_rr_pick.sv
// rtl/cr_rr_pick.sv - combinational N-way round-robin picker, search starts at ptr and wraps
module cr_rr_pick
   import cr_fifo_arb_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx
);

   localparam int GW = $clog2(N);

   logic found;
   int   j;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = GW'(j);
         end
      end
   end

endmodule

// File: rtl/cr_fifo_wr_arbiter.sv
// rtl/cr_fifo_wr_arbiter.sv - round-robin, burst-locked arbiter for a shared FIFO write port
module cr_fifo_wr_arbiter
   import cr_fifo_arb_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DW    = DW_DEF,
   parameter int SW    = SW_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_valid,
   input  logic [N-1:0]         req_last,
   input  logic [N*DW-1:0]      req_data,
   output logic [N-1:0]         req_ready,
   input  logic                 fifo_full,
   input  logic [SW-1:0]        fifo_free_slots,
   output logic                 fifo_wen,
   output logic [DW-1:0]        fifo_wdata,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 locked,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam int GW = idx_w(N);

   arb_state_t    state, state_next;
   logic [GW-1:0] owner, rr_ptr;
   logic [N-1:0]  pick_gnt;
   logic [GW-1:0] pick_idx;
   logic [GW-1:0] acc_idx, ptr_inc;
   logic [SW:0]   slots_left;
   logic [DW-1:0] acc_data;
   logic          credit_ok, accept, acc_last;

   // The write issued last edge is not yet reflected in free_slots; the extra bit keeps 0-1 negative.
   assign slots_left = {1'b0, fifo_free_slots} - {{SW{1'b0}}, fifo_wen};
   assign credit_ok  = !fifo_full && !slots_left[SW] && (slots_left != '0);

   cr_rr_pick #(.N(N)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   assign acc_idx  = (state == LOCK) ? owner : pick_idx;
   assign acc_last = req_last[acc_idx];
   assign acc_data = req_data[int'(acc_idx)*DW +: DW];
   assign ptr_inc  = (acc_idx == GW'(N - 1)) ? '0 : acc_idx + 1'b1;

   always_comb begin
      req_ready  = '0;
      state_next = state;
      if (state == IDLE) begin
         req_ready = pick_gnt & {N{credit_ok}};
      end else begin
         req_ready[owner] = credit_ok & req_valid[owner];
      end
      accept = |(req_ready & req_valid);
      if (accept) begin
         state_next = acc_last ? IDLE : LOCK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= '0;
         rr_ptr     <= '0;
         fifo_wen   <= 1'b0;
         fifo_wdata <= '0;
         grant_id   <= '0;
         locked     <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         state    <= state_next;
         locked   <= (state_next == LOCK);
         fifo_wen <= accept;
         if (accept) begin
            fifo_wdata <= acc_data;
            grant_id   <= acc_idx;
            if (acc_last) begin
               rr_ptr <= ptr_inc;
            end else begin
               owner <= acc_idx;
            end
         end
         if (|req_valid && !accept && !credit_ok && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cr_fifo_wr_arbiter.sv
// tb/tb_cr_fifo_wr_arbiter.sv - directed and random checks of cr_fifo_wr_arbiter against a reference model
module tb_cr_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int DW    = 71;
   localparam int SW    = 12;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid, req_last, req_ready;
   logic [N*DW-1:0]  req_data;
   logic             fifo_full, fifo_wen, locked;
   logic [SW-1:0]    fifo_free_slots;
   logic [DW-1:0]    fifo_wdata;
   logic [1:0]       grant_id;
   logic [CNT_W-1:0] stall_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   bit          started = 1'b0;
   int          m_ptr, m_owner, m_gid, m_stall;
   bit          m_locked, m_wen;
   logic [DW-1:0] m_wdata;
   logic [N-1:0]  m_acc;

   always #5 clk = ~clk;

   cr_fifo_wr_arbiter #(.N(N), .DW(DW), .SW(SW), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_last        (req_last),
      .req_data        (req_data),
      .req_ready       (req_ready),
      .fifo_full       (fifo_full),
      .fifo_free_slots (fifo_free_slots),
      .fifo_wen        (fifo_wen),
      .fifo_wdata      (fifo_wdata),
      .grant_id        (grant_id),
      .locked          (locked),
      .stall_cnt       (stall_cnt)
   );

   function automatic logic [DW-1:0] rnd_beat();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // One clock: check the combinational ready, advance the model from the spec rules, check registers.
   task automatic cycle(input bit do_rst);
      int win;
      bit credit;
      logic [N-1:0] exp_ready;
      rst = do_rst;
      #2;
      credit = !fifo_full && (int'(fifo_free_slots) - int'(m_wen) > 0);
      win = -1;
      if (m_locked) begin
         if (req_valid[m_owner]) win = m_owner;
      end else begin
         for (int k = 0; k < N; k++)
            if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      exp_ready = '0;
      if (win >= 0 && credit) exp_ready[win] = 1'b1;
      if (started) check("req_ready", 128'(req_ready), 128'(exp_ready));
      @(posedge clk);
      #1;
      if (do_rst) begin
         m_ptr = 0; m_owner = 0; m_gid = 0; m_stall = 0;
         m_locked = 1'b0; m_wen = 1'b0; m_wdata = '0; m_acc = '0;
      end else begin
         m_acc = exp_ready;
         if (win >= 0 && credit) begin
            m_wen   = 1'b1;
            m_wdata = req_data[win*DW +: DW];
            m_gid   = win;
            if (req_last[win]) begin
               m_locked = 1'b0;
               m_ptr    = (win + 1) % N;
            end else begin
               m_locked = 1'b1;
               m_owner  = win;
            end
         end else begin
            m_wen = 1'b0;
            if (|req_valid && !credit && m_stall < 65535) m_stall++;
         end
      end
      check("fifo_wen",   128'(fifo_wen),   128'(m_wen));
      check("fifo_wdata", 128'(fifo_wdata), 128'(m_wdata));
      check("grant_id",   128'(grant_id),   128'(m_gid));
      check("locked",     128'(locked),     128'(m_locked));
      check("stall_cnt",  128'(stall_cnt),  128'(m_stall));
   endtask

   task automatic fill_data();
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rnd_beat();
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
      fifo_full = 1'b0; fifo_free_slots = 12'd100;
      cycle(1);
      started = 1'b1;
      cycle(1);

      // all requesters single-beat: grants rotate 0,1,2,3 then back to 0
      req_valid = 4'b1111; req_last = 4'b1111;
      for (int c = 0; c < 5; c++) begin fill_data(); cycle(0); end
      req_valid = '0; cycle(0);

      // req1 three-beat burst holds off req2 until its last beat
      req_valid = 4'b0110; req_last = 4'b0100; fill_data(); cycle(0);
      fill_data(); cycle(0);
      req_last = 4'b0110; fill_data(); cycle(0);
      req_valid = 4'b0100; cycle(0);
      req_valid = '0; cycle(0);

      // one free slot: in-flight write removes the credit
      fifo_free_slots = 12'd1; req_valid = 4'b0011; req_last = 4'b0011; fill_data();
      cycle(0);
      cycle(0);
      fifo_free_slots = 12'd0; cycle(0); cycle(0);
      fifo_free_slots = 12'd4; cycle(0); cycle(0);

      // full overrides a non-zero free count
      fifo_full = 1'b1; fifo_free_slots = 12'd5; req_valid = 4'b1111;
      for (int c = 0; c < 3; c++) cycle(0);
      fifo_full = 1'b0; req_valid = '0; cycle(0);

      // reset in the middle of a locked burst
      req_valid = 4'b1000; req_last = 4'b0000; fill_data(); cycle(0); cycle(0);
      req_valid = 4'b1111; cycle(1);
      req_last = 4'b1111; cycle(0); cycle(0);
      req_valid = '0; cycle(0);

      // randomized traffic; producers hold valid/data until accepted
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || m_acc[i]) begin
               req_valid[i] = ($urandom % 3) != 0;
               req_last[i]  = ($urandom % 3) == 0;
               req_data[i*DW +: DW] = rnd_beat();
            end
         end
         fifo_full       = ($urandom % 8) == 0;
         fifo_free_slots = SW'($urandom % 4);
         cycle(0);
      end

      // long stall: counter must saturate at all-ones
      fifo_full = 1'b1; req_valid = 4'b0001;
      for (int c = 0; c < 65540; c++) cycle(0);
      check("stall_sat", 128'(stall_cnt), 128'(16'hFFFF));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
